// File: rtl/ble_uart_core.sv
// FIFO-buffered 8N1 UART transceiver driving the BLE module serial pins.
// Holds the TX/RX byte FIFOs, both bit engines, the input synchronisers and the sticky error flag.
module ble_uart_core #(
   parameter int unsigned BAUD_DIV   = 434,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_enable,
   output logic       uart_status,
   input  logic       write,
   input  logic [7:0] write_data,
   output logic       write_full,
   input  logic       read,
   output logic [7:0] read_data,
   output logic       read_empty,
   output logic       irq,
   output logic       error,
   input  logic       uart_rx,
   output logic       uart_tx,
   input  logic       ble_state
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0]   BIT_LAST  = 16'(BAUD_DIV - 1);
   localparam logic [15:0]   HALF_LAST = 16'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic          rx_s1_q, rx_s2_q, rx_prev_q, st_s1_q, st_s2_q;

   state_t        tx_state_q, tx_state_d;
   logic [15:0]   tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_idx_q, tx_idx_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_line_q, tx_line_d;
   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [AW-1:0] txf_wr_q, txf_wr_d, txf_rd_q, txf_rd_d;
   logic [CW-1:0] txf_cnt_q, txf_cnt_d;
   logic          txf_full_q, txf_full_d;
   logic          tx_push, tx_pop;

   state_t        rx_state_q, rx_state_d;
   logic [15:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [AW-1:0] rxf_wr_q, rxf_wr_d, rxf_rd_q, rxf_rd_d;
   logic [CW-1:0] rxf_cnt_q, rxf_cnt_d;
   logic          rxf_empty_q, rxf_empty_d;
   logic          rx_push, rx_pop;

   logic [7:0]    rd_data_q, rd_data_d;
   logic          irq_q, irq_d;
   logic          err_q, err_d;

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_idx_d    = tx_idx_q;
      tx_sh_d     = tx_sh_q;
      tx_line_d   = tx_line_q;
      txf_wr_d    = txf_wr_q;
      txf_rd_d    = txf_rd_q;
      txf_cnt_d   = txf_cnt_q;
      txf_full_d  = txf_full_q;
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_idx_d    = rx_idx_q;
      rx_sh_d     = rx_sh_q;
      rxf_wr_d    = rxf_wr_q;
      rxf_rd_d    = rxf_rd_q;
      rxf_cnt_d   = rxf_cnt_q;
      rxf_empty_d = rxf_empty_q;
      rd_data_d   = rd_data_q;
      irq_d       = 1'b0;
      err_d       = err_q;
      tx_push     = 1'b0;
      tx_pop      = 1'b0;
      rx_push     = 1'b0;
      rx_pop      = 1'b0;

      if (!uart_enable) begin
         tx_state_d  = S_IDLE;
         tx_cnt_d    = '0;
         tx_idx_d    = '0;
         tx_line_d   = 1'b1;
         txf_wr_d    = '0;
         txf_rd_d    = '0;
         txf_cnt_d   = '0;
         txf_full_d  = 1'b0;
         rx_state_d  = S_IDLE;
         rx_cnt_d    = '0;
         rx_idx_d    = '0;
         rxf_wr_d    = '0;
         rxf_rd_d    = '0;
         rxf_cnt_d   = '0;
         rxf_empty_d = 1'b1;
         err_d       = 1'b0;
      end else begin
         tx_push = write && !txf_full_q;
         case (tx_state_q)
            S_IDLE: tx_pop = (txf_cnt_q != '0);
            S_START: begin
               tx_cnt_d = tx_cnt_q + 16'd1;
               if (tx_cnt_q == BIT_LAST) begin
                  tx_state_d = S_DATA;
                  tx_cnt_d   = '0;
                  tx_idx_d   = '0;
                  tx_line_d  = tx_sh_q[0];
               end
            end
            S_DATA: begin
               tx_cnt_d = tx_cnt_q + 16'd1;
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_d = '0;
                  if (tx_idx_q == 3'd7) begin
                     tx_state_d = S_STOP;
                     tx_line_d  = 1'b1;
                  end else begin
                     tx_idx_d  = tx_idx_q + 3'd1;
                     tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                     tx_line_d = tx_sh_q[1];
                  end
               end
            end
            default: begin
               tx_cnt_d = tx_cnt_q + 16'd1;
               if (tx_cnt_q == BIT_LAST) begin
                  tx_state_d = S_IDLE;
                  tx_cnt_d   = '0;
                  // Reload straight from the end of STOP so queued frames run back-to-back.
                  tx_pop     = (txf_cnt_q != '0);
               end
            end
         endcase
         if (tx_pop) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_line_d  = 1'b0;
            tx_sh_d    = tx_mem_q[txf_rd_q];
            txf_rd_d   = txf_rd_q + AW'(1);
         end
         if (tx_push) txf_wr_d = txf_wr_q + AW'(1);
         txf_cnt_d  = txf_cnt_q + CW'(tx_push) - CW'(tx_pop);
         txf_full_d = (txf_cnt_d == DEPTH);

         case (rx_state_q)
            S_IDLE: begin
               rx_cnt_d = '0;
               if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
            end
            S_START: begin
               rx_cnt_d = rx_cnt_q + 16'd1;
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_d   = '0;
                  rx_idx_d   = '0;
                  rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               rx_cnt_d = rx_cnt_q + 16'd1;
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_d = '0;
                  rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                  if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
                  else                  rx_idx_d   = rx_idx_q + 3'd1;
               end
            end
            default: begin
               rx_cnt_d = rx_cnt_q + 16'd1;
               if (rx_cnt_q == BIT_LAST) begin
                  rx_state_d = S_IDLE;
                  rx_cnt_d   = '0;
                  if (!rx_s2_q || rxf_cnt_q == DEPTH) err_d = 1'b1;
                  else                                rx_push = 1'b1;
               end
            end
         endcase
         irq_d  = rx_push;
         rx_pop = read && !rxf_empty_q;
         if (rx_pop) begin
            rd_data_d = rx_mem_q[rxf_rd_q];
            rxf_rd_d  = rxf_rd_q + AW'(1);
         end
         if (rx_push) rxf_wr_d = rxf_wr_q + AW'(1);
         rxf_cnt_d   = rxf_cnt_q + CW'(rx_push) - CW'(rx_pop);
         rxf_empty_d = (rxf_cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[txf_wr_q] <= write_data;
      if (rx_push) rx_mem_q[rxf_wr_q] <= rx_sh_q;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         st_s1_q     <= 1'b0;
         st_s2_q     <= 1'b0;
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_idx_q    <= '0;
         tx_line_q   <= 1'b1;
         txf_wr_q    <= '0;
         txf_rd_q    <= '0;
         txf_cnt_q   <= '0;
         txf_full_q  <= 1'b0;
         rx_state_q  <= S_IDLE;
         rx_cnt_q    <= '0;
         rx_idx_q    <= '0;
         rxf_wr_q    <= '0;
         rxf_rd_q    <= '0;
         rxf_cnt_q   <= '0;
         rxf_empty_q <= 1'b1;
         rd_data_q   <= '0;
         irq_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         rx_s1_q     <= uart_rx;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
         st_s1_q     <= ble_state;
         st_s2_q     <= st_s1_q;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_idx_q    <= tx_idx_d;
         tx_line_q   <= tx_line_d;
         txf_wr_q    <= txf_wr_d;
         txf_rd_q    <= txf_rd_d;
         txf_cnt_q   <= txf_cnt_d;
         txf_full_q  <= txf_full_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_idx_q    <= rx_idx_d;
         rxf_wr_q    <= rxf_wr_d;
         rxf_rd_q    <= rxf_rd_d;
         rxf_cnt_q   <= rxf_cnt_d;
         rxf_empty_q <= rxf_empty_d;
         rd_data_q   <= rd_data_d;
         irq_q       <= irq_d;
         err_q       <= err_d;
      end
   end

   assign uart_status = st_s2_q;
   assign uart_tx     = tx_line_q;
   assign write_full  = txf_full_q;
   assign read_empty  = rxf_empty_q;
   assign read_data   = rd_data_q;
   assign irq         = irq_q;
   assign error       = err_q;
endmodule

// File: tb/tb_ble_uart_core.sv
// Directed/randomised bench for ble_uart_core at BAUD_DIV=8, FIFO_DEPTH=16.
// Expected serial frames and FIFO contents come from a byte-level 8N1 model.
module tb_ble_uart_core;
   localparam int B = 8;
   localparam int D = 16;

   logic       clk;
   logic       rst, uart_enable, write, read, uart_rx, ble_state;
   logic [7:0] write_data;
   logic       uart_status, write_full, read_empty, irq, error, uart_tx;
   logic [7:0] read_data;

   int          vectors = 0;
   int          miscompares = 0;
   int unsigned cyc = 0;
   int          irq_cnt = 0;
   int unsigned irq_cyc = 0;
   int unsigned fall_cyc = 0;
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];

   ble_uart_core #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .uart_enable(uart_enable), .uart_status(uart_status),
      .write(write), .write_data(write_data), .write_full(write_full),
      .read(read), .read_data(read_data), .read_empty(read_empty),
      .irq(irq), .error(error), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .ble_state(ble_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (irq === 1'b1) begin
         irq_cnt <= irq_cnt + 1;
         irq_cyc <= cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered on the first cycle of the start bit; returns on the cycle after the stop bit.
   task automatic check_frame(input string tag, input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         tick(B / 2);
         chk(tag, uart_tx, f[i]);
         tick(B - B / 2);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      fall_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         uart_rx = f[i];
         tick(B);
      end
      uart_rx = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      int         irq0;

      rst = 1'b1; uart_enable = 1'b0; write = 1'b0; read = 1'b0;
      uart_rx = 1'b1; ble_state = 1'b0; write_data = 8'h00;
      tick(3);
      chk("rst_tx", uart_tx, 1'b1);
      chk("rst_full", write_full, 1'b0);
      chk("rst_empty", read_empty, 1'b1);
      chk("rst_rdata", read_data, 8'h00);
      chk("rst_irq", irq, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_status", uart_status, 1'b0);
      rst = 1'b0;

      ble_state = 1'b1;
      tick(1);
      chk("status_sync1", uart_status, 1'b0);
      tick(1);
      chk("status_sync2", uart_status, 1'b1);

      write_data = 8'h55; write = 1'b1;
      tick(1);
      write = 1'b0; uart_enable = 1'b1;
      tick(6);
      chk("disabled_write_ignored", uart_tx, 1'b1);

      write_data = 8'hA5; write = 1'b1;
      tick(1);
      write = 1'b0;
      chk("tx_a5_n1", uart_tx, 1'b1);
      tick(1);
      chk("tx_a5_fall", uart_tx, 1'b0);
      check_frame("tx_a5_bit", 8'hA5);
      chk("tx_a5_c82", uart_tx, 1'b1);

      b = 8'($urandom);
      write_data = b; write = 1'b1;
      tick(1);
      write = 1'b0;
      tick(1);
      chk("tx_rand_fall", uart_tx, 1'b0);
      check_frame("tx_rand_bit", b);
      chk("tx_rand_idle", uart_tx, 1'b1);

      irq0 = irq_cnt;
      send_frame(8'h3C, 1'b1);
      chk("rx_3c_irq", irq_cnt, irq0 + 1);
      chk("rx_3c_latency", irq_cyc - fall_cyc, 3 + B / 2 + 9 * B);
      chk("rx_3c_nonempty", read_empty, 1'b0);
      read = 1'b1;
      tick(1);
      read = 1'b0;
      chk("rx_3c_data", read_data, 8'h3C);
      chk("rx_3c_empty", read_empty, 1'b1);

      write_data = 8'($urandom); write = 1'b1;
      tick(1);
      write = 1'b0;
      tick(1);
      for (int i = 0; i < 17; i++) begin
         write_data = 8'(i); write = 1'b1;
         tick(1);
         if (txq.size() < D) txq.push_back(8'(i));
         chk("burst_full", write_full, txq.size() == D);
      end
      write = 1'b0;
      tick(62);
      chk("burst_full_hold", write_full, 1'b1);
      tick(1);
      chk("burst_full_release", write_full, 1'b0);
      while (txq.size() > 0) check_frame("burst_frame", txq.pop_front());
      tick(4);
      chk("burst_dropped_idle", uart_tx, 1'b1);
      tick(36);
      chk("burst_dropped_idle2", uart_tx, 1'b1);

      irq0 = irq_cnt;
      send_frame(8'($urandom), 1'b0);
      tick(2);
      chk("frame_err_error", error, 1'b1);
      chk("frame_err_noirq", irq_cnt, irq0);
      chk("frame_err_empty", read_empty, 1'b1);
      uart_enable = 1'b0;
      tick(1);
      uart_enable = 1'b1;
      chk("frame_err_clear", error, 1'b0);
      tick(1);
      chk("frame_err_stays_clear", error, 1'b0);

      irq0 = irq_cnt;
      for (int k = 0; k < 17; k++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1);
         if (rxq.size() < D) rxq.push_back(b);
         if (k == 15) chk("fill_no_error", error, 1'b0);
      end
      chk("overrun_error", error, 1'b1);
      chk("overrun_irqs", irq_cnt, irq0 + rxq.size());
      chk("overrun_nonempty", read_empty, 1'b0);
      read = 1'b1;
      while (rxq.size() > 0) begin
         b = rxq.pop_front();
         tick(1);
         chk("fifo_order", read_data, b);
      end
      chk("drain_empty", read_empty, 1'b1);
      tick(1);
      read = 1'b0;
      chk("empty_read_holds", read_data, b);
      chk("empty_read_still_empty", read_empty, 1'b1);

      write_data = 8'($urandom); write = 1'b1;
      tick(1);
      write = 1'b0;
      tick(20);
      uart_rx = 1'b0;
      tick(30);
      rst = 1'b1; uart_rx = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_tx", uart_tx, 1'b1);
      chk("midrst_full", write_full, 1'b0);
      chk("midrst_empty", read_empty, 1'b1);
      chk("midrst_rdata", read_data, 8'h00);
      chk("midrst_irq", irq, 1'b0);
      chk("midrst_error", error, 1'b0);
      chk("midrst_status", uart_status, 1'b0);
      irq0 = irq_cnt;
      b = 8'($urandom);
      write_data = b; write = 1'b1;
      tick(1);
      write = 1'b0;
      chk("postrst_n1", uart_tx, 1'b1);
      tick(1);
      chk("postrst_fall", uart_tx, 1'b0);
      check_frame("postrst_bit", b);
      chk("postrst_idle", uart_tx, 1'b1);
      chk("postrst_no_irq", irq_cnt, irq0);
      chk("postrst_empty", read_empty, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
